// File: rtl/multichan_scfifo.sv
// Single-clock multi-channel FIFO: NUM_CH logical FIFOs share one memory with
// one write and one read port, each steered by a channel index.
module multichan_scfifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int NUM_CH        = 4,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    input  logic                    flush_en,
    input  logic [CH_W-1:0]         flush_ch,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       almost_empty,
    output logic [NUM_CH*CNT_W-1:0] usedw,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ADDR_W = CH_W + PTR_W;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [NUM_CH*DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic              wr_ch_ok, rd_ch_ok, flush_ok;
    logic              wr_flushed, rd_flushed;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;
    logic [PTR_W-1:0]  wr_ptr_sel, rd_ptr_sel;
    logic              wr_acc, rd_acc;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    // Accept decisions use only the counts registered at the start of the cycle.
    always_comb begin
        wr_ch_ok   = (32'(wr_ch) < NUM_CH);
        rd_ch_ok   = (32'(rd_ch) < NUM_CH);
        flush_ok   = flush_en && (32'(flush_ch) < NUM_CH);
        wr_flushed = flush_ok && (flush_ch == wr_ch);
        rd_flushed = flush_ok && (flush_ch == rd_ch);

        wr_cnt     = '0;
        wr_ptr_sel = '0;
        if (wr_ch_ok) begin
            wr_cnt     = count_q[wr_ch];
            wr_ptr_sel = wr_ptr_q[wr_ch];
        end
        rd_cnt     = '0;
        rd_ptr_sel = '0;
        if (rd_ch_ok) begin
            rd_cnt     = count_q[rd_ch];
            rd_ptr_sel = rd_ptr_q[rd_ch];
        end

        wr_acc      = wr_en && wr_ch_ok && !wr_flushed && (wr_cnt != DEPTH_C);
        rd_acc      = rd_en && rd_ch_ok && !rd_flushed && (rd_cnt != '0);
        overflow_d  = wr_en && wr_ch_ok && !wr_flushed && (wr_cnt == DEPTH_C);
        underflow_d = rd_en && rd_ch_ok && !rd_flushed && (rd_cnt == '0);

        wr_addr = {wr_ch, wr_ptr_sel};
        rd_addr = {rd_ch, rd_ptr_sel};
    end

    // A read needs count > 0 and a write needs count < DEPTH, so on a shared
    // channel the two addresses never collide: the read never sees the new word.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
            data_out_d = mem_q[rd_addr];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (flush_ok && (flush_ch == CH_W'(c))) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (wr_acc && (wr_ch == CH_W'(c))) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
                if (rd_acc && (rd_ch == CH_W'(c))) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                if ((wr_acc && (wr_ch == CH_W'(c))) && !(rd_acc && (rd_ch == CH_W'(c)))) begin
                    count_d[c] = count_q[c] + 1'b1;
                end else if (!(wr_acc && (wr_ch == CH_W'(c))) && (rd_acc && (rd_ch == CH_W'(c)))) begin
                    count_d[c] = count_q[c] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left uninitialised; counts alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        usedw        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]                  = (count_q[c] == DEPTH_C);
            empty[c]                 = (count_q[c] == '0);
            almost_full[c]           = (count_q[c] >= AFULL_C);
            almost_empty[c]          = (count_q[c] <= AEMPTY_C);
            usedw[c*CNT_W +: CNT_W]  = count_q[c];
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_multichan_scfifo.sv
// Bench for multichan_scfifo: per-channel queue model, read-data scoreboard
// and a negedge monitor that checks every output each cycle.
module tb_multichan_scfifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 5;
  localparam int AF_TH  = DEPTH - 2;
  localparam int AE_TH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b1;
  logic                    wr_en = 1'b0;
  logic [CH_W-1:0]         wr_ch = '0;
  logic [DW-1:0]           data_in = '0;
  logic                    rd_en = 1'b0;
  logic [CH_W-1:0]         rd_ch = '0;
  logic [DW-1:0]           data_out;
  logic                    rd_valid;
  logic                    flush_en = 1'b0;
  logic [CH_W-1:0]         flush_ch = '0;
  logic [NUM_CH-1:0]       full, empty, almost_full, almost_empty;
  logic [NUM_CH*CNT_W-1:0] usedw;
  logic                    overflow, underflow;

  multichan_scfifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .AFULL_THRESH(AF_TH), .AEMPTY_THRESH(AE_TH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_ch(wr_ch), .data_in(data_in),
    .rd_en(rd_en), .rd_ch(rd_ch), .data_out(data_out), .rd_valid(rd_valid),
    .flush_en(flush_en), .flush_ch(flush_ch),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .usedw(usedw), .overflow(overflow), .underflow(underflow)
  );

  // Reference model: one queue per channel holding its words oldest-first.
  logic [DW-1:0] mq [NUM_CH][$];
  logic [DW-1:0] exp_q [$];
  logic          exp_rv  = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic [DW-1:0] hold_dout = '0;
  int            checks = 0;
  int            errors = 0;
  bit            mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of requests, predicts the outcome from the model's
  // start-of-cycle state and commits the prediction after the clock edge.
  task automatic step(input logic rst, input logic we, input logic [CH_W-1:0] wc,
                      input logic [DW-1:0] d, input logic re, input logic [CH_W-1:0] rc,
                      input logic fe, input logic [CH_W-1:0] fc);
    logic wblk, rblk, wacc, racc, ovf, udf;
    logic [DW-1:0] rdat;
    reset = rst; wr_en = we; wr_ch = wc; data_in = d;
    rd_en = re; rd_ch = rc; flush_en = fe; flush_ch = fc;
    wblk = fe && (fc == wc);
    rblk = fe && (fc == rc);
    wacc = we && !wblk && (mq[wc].size() < DEPTH);
    ovf  = we && !wblk && (mq[wc].size() == DEPTH);
    racc = re && !rblk && (mq[rc].size() > 0);
    udf  = re && !rblk && (mq[rc].size() == 0);
    rdat = racc ? mq[rc][0] : '0;
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      exp_q.delete();
      exp_rv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0; hold_dout = '0;
    end else begin
      if (racc) begin
        void'(mq[rc].pop_front());
        exp_q.push_back(rdat);
      end
      if (wacc) mq[wc].push_back(d);
      if (fe) mq[fc].delete();
      exp_rv = racc; exp_ovf = ovf; exp_udf = udf;
    end
    #1;
  endtask

  task automatic wr(input logic [CH_W-1:0] c, input logic [DW-1:0] d);
    step(1'b0, 1'b1, c, d, 1'b0, '0, 1'b0, '0);
  endtask
  task automatic rd(input logic [CH_W-1:0] c);
    step(1'b0, 1'b0, '0, '0, 1'b1, c, 1'b0, '0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: status against the model, read data against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [NUM_CH-1:0]       e_full, e_empty, e_af, e_ae;
      logic [NUM_CH*CNT_W-1:0] e_usedw;
      logic [DW-1:0]           e_data;
      for (int c = 0; c < NUM_CH; c++) begin
        e_full[c]  = (mq[c].size() == DEPTH);
        e_empty[c] = (mq[c].size() == 0);
        e_af[c]    = (mq[c].size() >= AF_TH);
        e_ae[c]    = (mq[c].size() <= AE_TH);
        e_usedw[c*CNT_W +: CNT_W] = CNT_W'(mq[c].size());
      end
      check("usedw", 64'(usedw), 64'(e_usedw));
      check("full", 64'(full), 64'(e_full));
      check("empty", 64'(empty), 64'(e_empty));
      check("almost_full", 64'(almost_full), 64'(e_af));
      check("almost_empty", 64'(almost_empty), 64'(e_ae));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("underflow", 64'(underflow), 64'(exp_udf));
      check("rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_data actual=%0h expected=none (unexpected rd_valid) at %0t", data_out, $time);
        end else begin
          e_data = exp_q.pop_front();
          check("read_data", 64'(data_out), 64'(e_data));
          hold_dout = e_data;
        end
      end else begin
        check("data_hold", 64'(data_out), 64'(hold_dout));
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    mon_on = 1'b1;
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    idle();
    check("reset_empty", 64'(empty), 64'(4'b1111));
    check("reset_usedw", 64'(usedw), 64'd0);

    // Fill ch2 past full, then drain it.
    for (int i = 0; i < 16; i++) wr(2'd2, 8'(8'h10 + i));
    wr(2'd2, 8'hAA);
    idle();
    for (int i = 0; i < 16; i++) rd(2'd2);
    idle();

    // Interleaved channels.
    wr(2'd0, 8'h01); wr(2'd1, 8'h02); wr(2'd0, 8'h03);
    rd(2'd1); rd(2'd0); rd(2'd0);
    idle();

    // Simultaneous read/write on empty, then on full ch3.
    step(1'b0, 1'b1, 2'd3, 8'h55, 1'b1, 2'd3, 1'b0, '0);
    for (int i = 0; i < 15; i++) wr(2'd3, 8'(8'h60 + i));
    step(1'b0, 1'b1, 2'd3, 8'hEE, 1'b1, 2'd3, 1'b0, '0);
    for (int i = 0; i < 16; i++) rd(2'd3);
    idle();

    // Steady count 8 on ch1 across pointer wrap, then threshold sweep.
    for (int i = 0; i < 8; i++) wr(2'd1, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 2'd1, 8'(8'h90 + i), 1'b1, 2'd1, 1'b0, '0);
    for (int i = 0; i < 7; i++) wr(2'd1, 8'(8'hC0 + i));
    for (int i = 0; i < 13; i++) rd(2'd1);
    idle();

    // Flush ch0 with a same-cycle read; ch1 must survive.
    for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'h20 + i));
    wr(2'd1, 8'h77);
    step(1'b0, 1'b0, '0, '0, 1'b1, 2'd0, 1'b1, 2'd0);
    idle();
    rd(2'd1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'(i), 8'(8'h40 + i), 1'b1, 2'(i + 3), 1'b0, '0);
    step(1'b1, 1'b1, 2'd0, 8'h99, 1'b1, 2'd1, 1'b0, '0);
    idle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 99) < 60), 2'($urandom_range(0, NUM_CH - 1)), 8'($urandom),
           ($urandom_range(0, 99) < 55), 2'($urandom_range(0, NUM_CH - 1)),
           ($urandom_range(0, 39) == 0), 2'($urandom_range(0, NUM_CH - 1)));
    end
    idle();
    idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
